forward_scoreboard: RTL

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/forward_scoreboard.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/forward_scoreboard.sv
// forward_scoreboard: operand-forwarding select and pending-write scoreboard
// for a pipeline with a few bypass stages and multi-cycle units (divider/FPU).
// Each read port gets a source select (register file, a bypass stage, or the
// completion bus). A stall is raised when a read would see a register that a
// multi-cycle op has not yet written back.
//
// Handshake: a multi-cycle issue is accepted on a rising edge where
// iss_valid && iss_ready && no read-port hazard. iss_ready does not depend on
// iss_valid. A completion (cpl_valid) is not back-pressured; it is always
// consumed on the edge where it is presented.
module forward_scoreboard #(
  parameter int NUM_RD     = 3,
  parameter int FWD_STAGES = 2,
  parameter int MAX_OUT    = 4,
  localparam int CNT_W     = $clog2(MAX_OUT + 1),
  localparam int SEL_W     = $clog2(FWD_STAGES + 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD-1:0]       rd_valid,
  input  logic [NUM_RD*5-1:0]     rd_addr,
  input  logic [NUM_RD-1:0]       rd_is_fp,
  input  logic [FWD_STAGES-1:0]   stg_wr_en,
  input  logic [FWD_STAGES*5-1:0] stg_wr_addr,
  input  logic [FWD_STAGES-1:0]   stg_is_fp,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_rd,
  input  logic                    iss_is_fp,
  output logic                    iss_ready,
  input  logic                    cpl_valid,
  input  logic [4:0]              cpl_rd,
  input  logic                    cpl_is_fp,
  output logic [NUM_RD*SEL_W-1:0] fwd_sel,
  output logic                    stall,
  output logic [CNT_W-1:0]        outstanding,
  output logic                    busy
);

  // Same register: address and class agree; integer x0 is hardwired zero
  // and therefore never matches anything.
  function automatic logic reg_match(input logic [4:0] a, input logic a_fp,
                                     input logic [4:0] b, input logic b_fp);
    return (a == b) && (a_fp == b_fp) && (a_fp || (a != 5'd0));
  endfunction

  logic [31:0]      pend_int_q, pend_int_d;
  logic [31:0]      pend_fp_q,  pend_fp_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic [NUM_RD-1:0] port_hazard;
  logic              any_hazard;
  logic              iss_pend;
  logic              iss_cpl_hit;
  logic              waw_block;
  logic              iss_accept;
  logic              cpl_pend;
  logic              cpl_x0;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
    logic [4:0]       addr;
    logic             is_fp;
    logic             cpl_hit;
    logic             pend;
    logic [SEL_W-1:0] sel;

    assign addr    = rd_addr[gi*5 +: 5];
    assign is_fp   = rd_is_fp[gi];
    assign cpl_hit = cpl_valid && reg_match(addr, is_fp, cpl_rd, cpl_is_fp);
    assign pend    = is_fp ? pend_fp_q[addr] : pend_int_q[addr];
    // A completing result on the bus resolves the pending read this cycle.
    assign port_hazard[gi] = rd_valid[gi] && pend && !cpl_hit;

    // Source priority: completion bus, then youngest matching stage, else RF.
    always_comb begin
      sel = '0;
      if (rd_valid[gi]) begin
        if (cpl_hit) begin
          sel = SEL_W'(FWD_STAGES + 1);
        end else begin
          // Walk oldest to youngest so the lowest matching index wins.
          for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (stg_wr_en[k] &&
                reg_match(addr, is_fp, stg_wr_addr[k*5 +: 5], stg_is_fp[k]))
              sel = SEL_W'(k + 1);
          end
        end
      end
    end

    assign fwd_sel[gi*SEL_W +: SEL_W] = sel;
  end

  assign any_hazard  = |port_hazard;
  assign iss_pend    = iss_is_fp ? pend_fp_q[iss_rd] : pend_int_q[iss_rd];
  assign iss_cpl_hit = cpl_valid && reg_match(iss_rd, iss_is_fp, cpl_rd, cpl_is_fp);
  // A second write to a still-pending register must wait unless the first
  // one retires in this very cycle.
  assign waw_block   = iss_pend && !iss_cpl_hit;
  assign iss_ready   = ((cnt_q < CNT_W'(MAX_OUT)) || cpl_valid) && !waw_block;
  assign stall       = any_hazard || (iss_valid && !iss_ready);
  assign iss_accept  = iss_valid && iss_ready && !any_hazard;

  assign outstanding = cnt_q;
  assign busy        = (cnt_q != '0);

  // Pending-bit update: completion clears first, an accepted issue then sets,
  // so a same-register issue+completion leaves the bit set.
  always_comb begin
    pend_int_d = pend_int_q;
    pend_fp_d  = pend_fp_q;
    if (cpl_valid) begin
      if (cpl_is_fp) pend_fp_d[cpl_rd]  = 1'b0;
      else           pend_int_d[cpl_rd] = 1'b0;
    end
    if (iss_accept) begin
      if (iss_is_fp)            pend_fp_d[iss_rd]  = 1'b1;
      else if (iss_rd != 5'd0)  pend_int_d[iss_rd] = 1'b1;
    end
  end

  // Outstanding count: issue and completion in the same cycle cancel; a
  // stray completion cannot wrap the count below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (iss_accept && !cpl_valid)
      cnt_d = cnt_q + CNT_W'(1);
    else if (!iss_accept && cpl_valid && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_int_q <= '0;
      pend_fp_q  <= '0;
      cnt_q      <= '0;
    end else begin
      pend_int_q <= pend_int_d;
      pend_fp_q  <= pend_fp_d;
      cnt_q      <= cnt_d;
    end
  end

  // Integer x0 ops are counted but never tracked, so their completion has
  // no pending bit to match.
  assign cpl_pend = cpl_is_fp ? pend_fp_q[cpl_rd] : pend_int_q[cpl_rd];
  assign cpl_x0   = !cpl_is_fp && (cpl_rd == 5'd0);

  cpl_legal_a: assert property (@(posedge clk) disable iff (rst)
    cpl_valid |-> ((cnt_q != '0) && (cpl_pend || cpl_x0)));

endmodule
